// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and helpers for the N:1 TDM multiplexer
package tdm_pkg;
  localparam int MAX_NCH = 16;
  localparam logic [7:0] IDLE_PATTERN_DEF = 8'hBC;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: modulo-NCH slot counter, resets to the last slot so the first live edge captures
module tdm_slot_counter #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic          clk8f,
  input  logic          reset,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic          first
);
  assign last  = cnt == CW'(NCH - 1);
  assign first = cnt == '0;
  // advance one slot per clock, wrapping after the last slot
  always_ff @(posedge clk8f)
    if (!reset) cnt <= CW'(NCH - 1);
    else        cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/tdm_mux_n.sv
// tdm_mux_n: NCH:1 time-division mux on clk8f; define TDM_IDLE_FILL_EN to fill invalid slots with IDLE_PATTERN
module tdm_mux_n
  import tdm_pkg::*;
#(
  parameter int          NCH          = 4,
  parameter int          DW           = 8,
  parameter logic [7:0]  IDLE_PATTERN = IDLE_PATTERN_DEF,
  localparam int         CW           = clog2_min1(NCH)
) (
  input  logic              clk8f,
  input  logic              reset,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH-1:0]    valid_in,
  output logic [DW-1:0]     data_out,
  output logic              valid_out,
  output logic [CW-1:0]     ch_out,
  output logic              sof
);
`ifdef TDM_IDLE_FILL_EN
  localparam logic [DW-1:0] FILL = DW'(IDLE_PATTERN);
`else
  localparam logic [DW-1:0] FILL = DW'(IDLE_PATTERN) & '0;
`endif
  logic [CW-1:0]  cnt;
  logic           last;
  logic           first;
  logic [DW-1:0]  hold_data [NCH];
  logic [NCH-1:0] hold_valid;
  tdm_slot_counter #(.NCH(NCH), .CW(CW)) u_cnt (
    .clk8f (clk8f),
    .reset (reset),
    .cnt   (cnt),
    .last  (last),
    .first (first)
  );
  // capture all lanes once per frame and emit the held frame one slot per cycle
  always_ff @(posedge clk8f)
    if (!reset) begin
      hold_data  <= '{default: '0};
      hold_valid <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      ch_out     <= '0;
      sof        <= 1'b0;
    end else begin
      if (last) begin
        for (int k = 0; k < NCH; k++) hold_data[k] <= data_in[k*DW +: DW];
        hold_valid <= valid_in;
      end
      data_out  <= hold_valid[cnt] ? hold_data[cnt] : FILL;
      valid_out <= hold_valid[cnt];
      ch_out    <= cnt;
      sof       <= first;
    end
endmodule

// File: tb/tb_tdm_mux_n.sv
// tb_tdm_mux_n: checks an NCH=2 and an NCH=4 instance against a frame-indexed reference model
module tb_tdm_mux_n;
`ifdef TDM_IDLE_FILL_EN
  localparam logic [7:0] FILL = 8'hBC;
`else
  localparam logic [7:0] FILL = 8'h00;
`endif
  logic clk8f = 1'b0;
  logic reset = 1'b0;
  logic [15:0] d2 = '0;
  logic [1:0]  v2 = '0;
  logic [7:0]  do2;
  logic        vo2, co2, sof2;
  logic [31:0] d4 = '0;
  logic [3:0]  v4 = '0;
  logic [7:0]  do4;
  logic        vo4, sof4;
  logic [1:0]  co4;
  int checks = 0;
  int errors = 0;
  int nxt [2];
  logic [7:0] fd [2][64][4];
  logic       fv [2][64][4];
  logic [7:0] ed [2];
  logic       ev [2];
  int         ech [2];
  logic       es [2];

  always #5 clk8f = ~clk8f;

  tdm_mux_n #(.NCH(2), .DW(8)) u2 (
    .clk8f(clk8f), .reset(reset), .data_in(d2), .valid_in(v2),
    .data_out(do2), .valid_out(vo2), .ch_out(co2), .sof(sof2)
  );
  tdm_mux_n #(.NCH(4), .DW(8)) u4 (
    .clk8f(clk8f), .reset(reset), .data_in(d4), .valid_in(v4),
    .data_out(do4), .valid_out(vo4), .ch_out(co4), .sof(sof4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: edge t after release emits slot (t-1)%N of the frame captured at edge ((t-1)/N)*N
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int nn, tt, s, f;
      nn = i ? 4 : 2;
      tt = nxt[i];
      if (!reset) begin
        ed[i] = 0; ev[i] = 0; ech[i] = 0; es[i] = 0; nxt[i] = 0;
      end else begin
        if (tt == 0) begin
          ech[i] = nn - 1; ev[i] = 0; ed[i] = FILL; es[i] = 0;
        end else begin
          s = (tt - 1) % nn;
          f = ((tt - 1) / nn) % 64;
          ech[i] = s;
          ev[i]  = fv[i][f][s];
          ed[i]  = ev[i] ? fd[i][f][s] : FILL;
          es[i]  = (s == 0);
        end
        if (tt % nn == 0)
          for (int k = 0; k < nn; k++) begin
            fd[i][(tt / nn) % 64][k] = i ? d4[k*8 +: 8] : d2[k*8 +: 8];
            fv[i][(tt / nn) % 64][k] = i ? v4[k] : v2[k];
          end
        nxt[i] = tt + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk8f);
    model_step();
    @(negedge clk8f);
    chk("n2_data", do2, ed[0]);
    chk("n2_valid", vo2, ev[0]);
    chk("n2_ch", co2, ech[0]);
    chk("n2_sof", sof2, es[0]);
    chk("n4_data", do4, ed[1]);
    chk("n4_valid", vo4, ev[1]);
    chk("n4_ch", co4, ech[1]);
    chk("n4_sof", sof4, es[1]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    d2 = {8'hFF, 8'h11};
    d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    v4 = 4'hF;
    repeat (4) tick();
    chk("rst_data", do2, 0);
    chk("rst_valid", vo2, 0);
    chk("rst_sof", sof2, 0);
    reset = 1'b1;
    tick();
    chk("rel_ch", co2, 1);
    chk("rel_valid", vo2, 0);
    tick();
    chk("rel_sof", sof2, 1);
    chk("rel_data", do2, FILL);
    repeat (3) tick();
    // one valid lane
    v2 = 2'b01;
    d2 = {8'hFD, 8'h13};
    repeat (3) tick();
    for (int j = 0; j < 4 && sof2 !== 1'b1; j++) tick();
    chk("v01_s0_data", do2, 8'h13);
    chk("v01_s0_valid", vo2, 1);
    chk("v01_s0_ch", co2, 0);
    tick();
    chk("v01_s1_data", do2, FILL);
    chk("v01_s1_valid", vo2, 0);
    chk("v01_s1_sof", sof2, 0);
    // mid-frame change is invisible
    v2 = 2'b11;
    d2 = {8'hF5, 8'h1B};
    repeat (2) tick();
    for (int j = 0; j < 4 && co2 !== 1'b1; j++) tick();
    chk("mid_sync", co2, 1);
    d2 = {8'hF4, 8'h1C};
    tick();
    chk("mid_a", do2, 8'h1B);
    tick();
    chk("mid_b", do2, 8'hF5);
    tick();
    chk("mid_c", do2, 8'h1C);
    tick();
    chk("mid_d", do2, 8'hF4);
    // four-channel ordering and latency
    for (int j = 0; j < 6 && co4 !== 2'd3; j++) tick();
    chk("n4_sync", co4, 3);
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("n4_seq", do4, 8'hA0 + 8'(r % 4));
      chk("n4_sofseq", sof4, r % 4 == 0);
    end
    // reset in the middle of a frame
    for (int j = 0; j < 6 && co4 !== 2'd2; j++) tick();
    chk("mr_sync", co4, 2);
    reset = 1'b0;
    tick();
    chk("mr_data", do4, 0);
    chk("mr_ch", co4, 0);
    chk("mr_valid", vo4, 0);
    reset = 1'b1;
    tick();
    chk("mr_rel_ch", co4, 3);
    chk("mr_rel_valid", vo4, 0);
    tick();
    chk("mr_sof", sof4, 1);
    chk("mr_a0", do4, 8'hA0);
    // all lanes invalid
    v4 = 4'h0;
    d4 = 32'h5566_7788;
    repeat (5) tick();
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("inv_valid", vo4, 0);
      chk("inv_data", do4, FILL);
    end
    // random traffic with occasional resets
    for (int r = 0; r < 400; r++) begin
      d2 = 16'($urandom);
      v2 = 2'($urandom);
      d4 = $urandom;
      v4 = 4'($urandom);
      reset = ($urandom_range(0, 40) != 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_mux_n.md
Name: tdm_mux_n

Overview:
- Parametrised N:1 time-division multiplexer, the successor of the fixed 2-channel byte mux in the serial transmit path.
- Runs entirely on the fast clock `clk8f`. An internal slot counter replaces the divided clocks (`clkf`/`clk2f`/`clk4f`).
- Once per frame it samples NCH parallel data/valid lanes. It then emits them one per cycle with channel tag and start-of-frame marker, feeding the downstream serialiser.

Parameters:
- NCH, 4, number of input channels (legal: 2..16).
- DW, 8, data width per channel in bits.
- IDLE_PATTERN, 8'hBC, fill word for invalid slots. Used only when TDM_IDLE_FILL_EN is defined; truncated/zero-extended to DW.
- Local CW = max(1, $clog2(NCH)), channel-tag width.

Ports:
- clk8f  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk8f.
- data_in  in  NCH*DW  packed lanes; channel k occupies bits [k*DW +: DW].
- valid_in  in  NCH  per-channel valid; bit k qualifies lane k.
- data_out  out  DW  registered multiplexed data.
- valid_out  out  1  registered valid for current slot.
- ch_out  out  CW  registered channel index of current slot.
- sof  out  1  registered; high during slot 0 of every frame.

Behaviour:
- Reset (reset==0 at a rising edge):
  - slot counter cnt <= NCH-1.
  - hold_data[*] <= 0 and hold_valid[*] <= 0.
  - data_out <= 0, valid_out <= 0, ch_out <= 0, sof <= 0.
  - Reset asserted mid-frame aborts the frame immediately. No partial frame resumes.
- Frame: NCH cycles. cnt runs 0..NCH-1 and wraps to 0. No gaps and no stall input; the frame rate is clk8f/NCH.
- Capture: on every edge where cnt==NCH-1 (reset high), hold_data/hold_valid <= data_in/valid_in, all lanes together. Inputs need only be stable at that edge.
- Output, every non-reset edge:
  - data_out <= hold_valid[cnt] ? hold_data[cnt] : fill.
  - valid_out <= hold_valid[cnt].
  - ch_out <= cnt.
  - sof <= (cnt==0).
  - fill = 0 unless the optional feature is enabled.
- Simultaneous capture and output at cnt==NCH-1: output uses the OLD hold[NCH-1] (registered semantics); the new capture takes effect from the next slot 0.
- Latency: channel k of a frame captured at edge E appears on the outputs after edge E+1+k. Channel 0 appears one cycle after capture.
- First edge after reset release: captures the inputs and outputs slot NCH-1 of an empty frame (valid_out=0, data 0, ch_out=NCH-1, sof=0). The first real sof follows on the next edge.
- valid_out=0 slots still occupy their cycle; there is no compaction.

Optional Feature:
- Macro: TDM_IDLE_FILL_EN.
- Defined: invalid slots drive data_out=IDLE_PATTERN (lower DW bits), giving the serialiser a recognisable comma/idle symbol.
- Undefined: invalid slots drive data_out=0. IDLE_PATTERN is ignored and no extra logic is generated.
- valid_out, ch_out and sof are identical in both builds.

Decomposition:
- Package tdm_pkg:
  - Function clog2-with-min-1 for CW.
  - Default IDLE_PATTERN constant.
  - Localparam MAX_NCH=16.
- One sub-module, tdm_slot_counter: modulo-NCH counter with synchronous active-low reset to NCH-1. It outputs cnt, last (cnt==NCH-1) and first (cnt==0).
- Capture registers and the output mux stay in the top.

Test Plan:
- NCH=2, DW=8: hold reset low 4 edges with data_in={8'hFF,8'h11}.
  - During reset: all outputs 0.
  - After release: first edge ch_out=1, valid_out=0.
  - Then alternating outputs, data 0 because valid=0.
- NCH=2: valid_in=2'b01, lanes ch0=8'h13, ch1=8'hFD.
  - Slot 0: data_out=8'h13, valid_out=1, sof=1, ch_out=0.
  - Slot 1: data_out=8'h00 (8'hBC with TDM_IDLE_FILL_EN), valid_out=0, sof=0.
- NCH=2: valid_in=2'b11 with ch0=8'h1B, ch1=8'hF5, changed to 8'h1C/8'hF4 on the cycle after capture.
  - Frame outputs 1B then F5.
  - Next frame outputs 1C then F4.
  - Confirms a mid-frame input change is invisible.
- NCH=4, DW=8, lanes 8'hA0..8'hA3, all valid.
  - Output sequence A0,A1,A2,A3 repeats with ch_out 0..3.
  - sof high only on A0; capture-to-A0 latency is 1 cycle.
- Reset pulled low while ch_out==2 (NCH=4).
  - Next edge: all outputs 0.
  - After release: empty slot 3 (valid_out=0) precedes a fresh sof frame.
- Channel k of a frame with valid_in all 0: valid_out stays 0 for the full frame while sof and ch_out still cycle normally.
